// File: rtl/ram2p_fifo_ctrl.sv
// ram2p_fifo_ctrl: FIFO controller over a two-port RAM (A writes, B reads) with a 2-entry prefetch buffer.
// Define RAM2P_FIFO_FLUSH_EN to add the synchronous flush port.
module ram2p_fifo_ctrl #(
   parameter int DEPTH = 256,
   parameter int AWID  = 8,
   parameter int DWID  = 16
) (
   input  logic            clk,
   input  logic            rst,
`ifdef RAM2P_FIFO_FLUSH_EN
   input  logic            flush,
`endif
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DWID-1:0] in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DWID-1:0] out_data,
   output logic [AWID:0]   level,
   output logic            a_we,
   output logic [AWID-1:0] a_addr,
   output logic [DWID-1:0] a_din,
   output logic            b_we,
   output logic [AWID-1:0] b_addr,
   output logic [DWID-1:0] b_din,
   input  logic [DWID-1:0] b_dout
);
   logic [AWID-1:0] wr_ptr, rd_ptr;
   logic [AWID:0]   ram_cnt;
   logic            inflight, run, fl, push, pop, rd_en;
   logic [1:0]      buf_cnt, cnt_left;
   logic [DWID-1:0] buf0, buf1;
`ifdef RAM2P_FIFO_FLUSH_EN
   assign fl = flush;
`else
   assign fl = 1'b0;
`endif
   function automatic logic [AWID-1:0] inc(input logic [AWID-1:0] p);
      return (p == AWID'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   // run keeps in_ready low while rst is held and until the first edge after release
   always_comb begin
      in_ready  = run && !fl && (level < (AWID+1)'(DEPTH));
      push      = in_valid && in_ready;
      out_valid = buf_cnt != 2'd0;
      pop       = out_valid && out_ready;
      cnt_left  = buf_cnt - {1'b0, pop};
      rd_en     = !fl && (ram_cnt != '0) && ((cnt_left + {1'b0, inflight}) < 2'd2);
      a_we      = push;
      a_addr    = wr_ptr;
      a_din     = in_data;
      b_we      = 1'b0;
      b_addr    = rd_ptr;
      b_din     = '0;
      out_data  = buf0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run      <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
         buf_cnt  <= '0;
         buf0     <= '0;
         buf1     <= '0;
         level    <= '0;
      end else begin
         run <= 1'b1;
         if (fl) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            buf_cnt  <= '0;
            level    <= '0;
         end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (rd_en) rd_ptr <= inc(rd_ptr);
            ram_cnt  <= ram_cnt + (AWID+1)'(push) - (AWID+1)'(rd_en);
            inflight <= rd_en;
            buf_cnt  <= cnt_left + {1'b0, inflight};
            // captured word lands in the first free slot after the head shift
            buf0     <= (pop && buf_cnt == 2'd2) ? buf1 : (inflight && cnt_left == 2'd0) ? b_dout : buf0;
            buf1     <= (inflight && cnt_left == 2'd1) ? b_dout : buf1;
            level    <= level + (AWID+1)'(push) - (AWID+1)'(pop);
         end
      end
   end
endmodule

// File: tb/tb_ram2p_fifo_ctrl.sv
// tb_ram2p_fifo_ctrl: random and directed stimulus against a queue reference model and a behavioural RAM.
module tb_ram2p_fifo_ctrl;
   localparam int DEPTH = 256;
   localparam int AWID  = 8;
   localparam int DWID  = 16;
   logic            clk = 0, rst = 1, in_valid = 0, out_ready = 0, flush = 0;
   logic [DWID-1:0] in_data = '0;
   logic            in_ready, out_valid, a_we, b_we;
   logic [DWID-1:0] out_data, a_din, b_din, b_dout;
   logic [AWID:0]   level;
   logic [AWID-1:0] a_addr, b_addr;
   logic [DWID-1:0] mem [DEPTH];
   logic [DWID-1:0] q [$];
   logic            s_ov, s_ir;
   logic [AWID:0]   s_lvl;
   int              errors = 0, checks = 0;

   always #5 clk = ~clk;

   ram2p_fifo_ctrl #(.DEPTH(DEPTH), .AWID(AWID), .DWID(DWID)) dut (
      .clk(clk), .rst(rst),
`ifdef RAM2P_FIFO_FLUSH_EN
      .flush(flush),
`endif
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level),
      .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
      .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout)
   );

   // registered-read RAM; a same-address read during write returns a poison word
   always @(posedge clk) begin
      if (a_we) mem[a_addr] <= a_din;
      b_dout <= (a_we && a_addr == b_addr) ? 16'hDEAD : mem[b_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic iv, input logic [DWID-1:0] id, input logic ordy);
      in_valid = iv; in_data = id; out_ready = ordy;
      @(negedge clk);
      s_ov = out_valid; s_ir = in_ready; s_lvl = level;
      check("level", 32'(level), 32'(q.size()));
      check("in_ready", 32'(in_ready), 32'(!flush && q.size() < DEPTH));
      check("b_port_tied", {b_we, b_din}, 0);
      if (out_valid && out_ready) begin
         if (q.size() == 0) check("pop_when_model_empty", 1, 0);
         else check("out_data", 32'(out_data), 32'(q.pop_front()));
      end
      if (in_valid && in_ready) q.push_back(in_data);
      @(posedge clk); #1;
   endtask

   task automatic drain(input int bound, output int n);
      n = 0;
      while (q.size() != 0 && n < bound) begin
         step(0, '0, 1);
         n++;
      end
      check("drain_done", 32'(q.size()), 0);
      step(0, '0, 0);
      check("drain_ov", 32'(s_ov), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ir"}, 32'(in_ready), 0);
      check({tag, "_ov"}, 32'(out_valid), 0);
      check({tag, "_lvl"}, 32'(level), 0);
   endtask

   initial begin
      int n, pushes, cyc;
      logic [AWID:0] max_lvl;
      logic iv;
      repeat (3) @(posedge clk); #1;
      check_reset_outputs("rst0");
      check("rst0_data", 32'(out_data), 0);
      @(negedge clk) rst = 0;
      @(posedge clk); #1;
      step(1, 16'h0001, 1); check("lat_pre", 32'(s_ov), 0);
      step(0, '0, 1);       check("lat_t1", 32'(s_ov), 0);
      step(0, '0, 1);       check("lat_t2", 32'(s_ov), 0);
      step(0, '0, 1);       check("lat_t3", 32'(s_ov), 1);
      step(0, '0, 0);       check("lat_lvl", 32'(s_lvl), 0);
      for (int i = 0; i < DEPTH; i++) step(1, 16'(i), 0);
      step(1, 16'hFFFF, 0);
      check("full_ir", 32'(s_ir), 0);
      check("full_lvl", 32'(s_lvl), DEPTH);
      step(1, 16'hAAAA, 1);
      check("full_pop_ir", 32'(s_ir), 0);
      drain(300, n);
      check("drain_cycles", 32'(n + 1), DEPTH);
      max_lvl = '0;
      for (int k = 0; k < 1000; k++) begin
         step(1, 16'(k + 16'h1000), 1);
         if (s_lvl > max_lvl) max_lvl = s_lvl;
      end
      check("cont_maxlvl_le3", 32'(max_lvl <= 3), 1);
      drain(10, n);
      pushes = 0; cyc = 0;
      while (pushes < 5000 && cyc < 20000) begin
         iv = $urandom_range(0, 9) < 7;
         step(iv, 16'($urandom), 1'($urandom_range(0, 1)));
         if (iv && s_ir) pushes++;
         cyc++;
      end
      check("rand_pushes", 32'(pushes), 5000);
      drain(2000, n);
      for (int i = 0; i < 10; i++) step(1, 16'(16'h0200 + i), 0);
      step(0, '0, 1);
      rst = 1; #1;
      check_reset_outputs("rst_mid");
      repeat (2) @(posedge clk); #1;
      check_reset_outputs("rst_hold");
      q.delete();
      @(negedge clk) rst = 0;
      @(posedge clk); #1;
      step(1, 16'hBEEF, 1);
      drain(10, n);
      check("beef_cycles", 32'(n), 3);
`ifdef RAM2P_FIFO_FLUSH_EN
      for (int i = 0; i < 5; i++) step(1, 16'(16'h0300 + i), 0);
      flush = 1;
      step(1, 16'h5555, 0);
      q.delete();
      flush = 0;
      step(0, '0, 0);
      check("flush_lvl", 32'(s_lvl), 0);
      check("flush_ov", 32'(s_ov), 0);
      step(1, 16'h1234, 1);
      drain(10, n);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ram2p_fifo_ctrl.md
Name: ram2p_fifo_ctrl

Overview:
- Synchronous FIFO controller that owns both ports of the two-port RAM block.
- Port A of the RAM is used only for writes. Port B is used only for reads.
- Upstream side is a valid/ready push interface; downstream side is a valid/ready pop interface.
- A 2-entry output prefetch buffer hides the RAM's 1-cycle registered read latency and sustains 1 word/cycle.

Parameters:
DEPTH, 256, FIFO capacity in words; RAM depth; must be <= 2**AWID
AWID, 8, RAM address width
DWID, 16, data width

Ports:
clk  input  1  clock; same clock drives both RAM ports
rst  input  1  asynchronous, active-high reset
in_valid  input  1  push request
in_ready  output  1  push accept; transfer when in_valid && in_ready
in_data  input  DWID  push data
out_valid  output  1  pop data available
out_ready  input  1  pop accept; transfer when out_valid && out_ready
out_data  output  DWID  pop data (head of buffer)
level  output  AWID+1  total words held (RAM + in-flight + buffer)
a_we  output  1  RAM port A write enable
a_addr  output  AWID  RAM port A address
a_din  output  DWID  RAM port A write data
b_we  output  1  RAM port B write enable; tied 0
b_addr  output  AWID  RAM port B address
b_din  output  DWID  RAM port B write data; tied 0
b_dout  input  DWID  RAM port B registered read data
flush  input  1  synchronous clear; present only with RAM2P_FIFO_FLUSH_EN

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, ram_cnt=0, inflight=0, buf_cnt=0.
  - Outputs during reset: in_ready=0, out_valid=0, out_data=0, level=0.
  - in_ready goes high in the first cycle after rst deasserts.
- Push:
  - in_ready = (level < DEPTH).
  - a_we = in_valid && in_ready (combinational); a_addr = wr_ptr; a_din = in_data.
  - On push, wr_ptr advances; wraps DEPTH-1 -> 0.
- Read issue:
  - Condition (combinational): rd_en = (ram_cnt != 0) && (buf_cnt + inflight - pop) < 2, where pop = out_valid && out_ready.
  - b_addr = rd_ptr. On rd_en, rd_ptr advances with the same wrap rule, and inflight is set to 1 for the next cycle.
  - b_addr holds its value when rd_en=0.
- Read capture: when inflight=1, b_dout is written into the buffer tail at the next edge.
- Buffer: 2 entries. out_data = head entry, out_valid = (buf_cnt != 0). Head shifts on pop.
  - Capture and pop in the same cycle are legal.
- Counts: ram_cnt += push, -= rd_en. level = ram_cnt + inflight + buf_cnt, registered.
- Latency: a word accepted at edge T appears on out_valid/out_data after edge T+2 when the FIFO is empty.
  - Steady state with out_ready=1 and in_valid=1: 1 word/cycle in and out.
- No read/write collision: reads occur only when ram_cnt != 0, so b_addr never equals a word being written in the same cycle.
  - The RAM's same-address read-during-write result is therefore never used.
- Full: at level == DEPTH, in_ready=0 and in_data is ignored.
  - A pop in that cycle does not enable a push in the same cycle; in_ready rises the cycle after.
- Empty: out_valid=0; out_data holds its last value (0 after reset).
- Wrap-around: pointers wrap modulo DEPTH, including when DEPTH is not a power of two.
- Reset mid-operation: all contents are dropped. An in-flight read is discarded and is never captured after reset.
- Data ordering: strict FIFO order; no word is lost or duplicated under any out_ready pattern.

Optional Feature:
- Macro: RAM2P_FIFO_FLUSH_EN.
- Defined:
  - The flush port exists.
  - When flush=1 at an edge: pointers, ram_cnt, inflight and buf_cnt clear to 0. Any in-flight b_dout is discarded.
  - While flush=1: in_ready=0 and rd_en=0.
  - out_valid is 0 after that edge; pushes resume the cycle after flush deasserts.
- Undefined:
  - No flush port; the controller clears only through rst.

Test Plan:
- Reset, then push 0x0001 with out_ready=1 -> out_valid=1 with out_data=0x0001 two cycles after the accept edge; level returns to 0.
- Push 256 words (0x0000..0x00FF) with out_ready=0 -> in_ready=0 with level=256. A 257th push is not accepted.
  - Then drain with out_ready=1 -> 0x0000..0x00FF in order, one word/cycle after a 2-cycle initial latency.
- Continuous push and pop, 1000 incrementing words, out_ready=1 -> in_ready stays 1, output matches input, level <= 3, pointers wrap past 255.
- Random out_ready (50%) and random in_valid (70%), 5000 words -> exact order match, no drops or duplicates. b_we is always 0, and b_addr never equals a_addr while a_we=1.
- Assert rst with 10 words queued and a read in flight -> out_valid=0, level=0, in_ready=0 during reset.
  - After release, push 0xBEEF -> out_data=0xBEEF (no stale data).
- With RAM2P_FIFO_FLUSH_EN defined: 5 words queued, flush pulsed for 1 cycle -> level=0, out_valid=0.
  - Next push 0x1234 -> popped as the first word.
